// File: rtl/gated_current_unit.sv
// gated_current_unit
// Computes one Hodgkin-Huxley style channel current per request:
//     I = G_MAX * x^POW * (V - E_REV)
// in signed Q(W-FRAC).FRAC fixed point, using one shared saturating multiplier
// that is stepped through a small FSM (IDLE -> POWR -> GAIN -> DRIVE -> HOLD).
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   V and x are presented
//   in_ready   out  a request is accepted this cycle (IDLE with no pending result)
//   V          in   membrane potential, signed W bits
//   x          in   gating variable (n, m or h), signed W bits
//   out_valid  out  I_out / out_sat hold a result
//   out_ready  in   consumer takes the result
//   I_out      out  computed current, signed W bits
//   out_sat    out  any step of this result saturated
module gated_current_unit #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int POW   = 4,
    parameter int G_MAX = 9216,
    parameter int E_REV = -3072
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] V,
    input  logic signed [W-1:0] x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] I_out,
    output logic                out_sat
);

    localparam int unsigned CW = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POWR  = 3'd1;
    localparam logic [2:0] S_GAIN  = 3'd2;
    localparam logic [2:0] S_DRIVE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic signed [W-1:0]   MAX_Q = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MIN_Q = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*W-1:0] P_MAX = (2*W)'(MAX_Q);
    localparam logic signed [2*W-1:0] P_MIN = (2*W)'(MIN_Q);
    localparam logic signed [W-1:0]   G_Q   = W'(G_MAX);
    localparam logic signed [W-1:0]   E_Q   = W'(E_REV);

    // Saturating fixed-point multiply; returns {saturated, result}.
    function automatic logic [W:0] mul_sat(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        p = p >>> FRAC;
        if (p > P_MAX)      mul_sat = {1'b1, MAX_Q};
        else if (p < P_MIN) mul_sat = {1'b1, MIN_Q};
        else                mul_sat = {1'b0, p[W-1:0]};
    endfunction

    logic [2:0]          r_state, w_state_nxt;
    logic signed [W-1:0] r_acc, w_acc_nxt;
    logic signed [W-1:0] r_d, w_d_nxt;
    logic signed [W-1:0] r_x, w_x_nxt;
    logic                r_sat, w_sat_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic signed [W-1:0] r_i_out, w_i_out_nxt;
    logic                r_out_sat, w_out_sat_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic                r_in_ready, w_in_ready_nxt;

    logic signed [W:0]   w_sub;
    logic                w_sub_sat;
    logic signed [W-1:0] w_sub_q;
    logic signed [W-1:0] w_mul_b;
    logic [W:0]          w_mul;

    // V - E_REV at W+1 bits, clamped back to W bits
    always_comb begin
        w_sub     = {V[W-1], V} - {E_Q[W-1], E_Q};
        w_sub_sat = (w_sub[W] != w_sub[W-1]);
        if (w_sub_sat) w_sub_q = w_sub[W] ? MIN_Q : MAX_Q;
        else           w_sub_q = w_sub[W-1:0];
    end

    // Second multiplier operand depends on which step is running
    always_comb begin
        w_mul_b = r_x;
        if (r_state == S_GAIN)  w_mul_b = G_Q;
        if (r_state == S_DRIVE) w_mul_b = r_d;
        w_mul = mul_sat(r_acc, w_mul_b);
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_d         <= '0;
            r_x         <= '0;
            r_sat       <= 1'b0;
            r_cnt       <= '0;
            r_i_out     <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_d         <= w_d_nxt;
            r_x         <= w_x_nxt;
            r_sat       <= w_sat_nxt;
            r_cnt       <= w_cnt_nxt;
            r_i_out     <= w_i_out_nxt;
            r_out_sat   <= w_out_sat_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_d_nxt         = r_d;
        w_x_nxt         = r_x;
        w_sat_nxt       = r_sat;
        w_cnt_nxt       = r_cnt;
        w_i_out_nxt     = r_i_out;
        w_out_sat_nxt   = r_out_sat;
        w_out_valid_nxt = r_out_valid;
        w_in_ready_nxt  = r_in_ready;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_d_nxt        = w_sub_q;
                    w_sat_nxt      = w_sub_sat;
                    w_acc_nxt      = x;
                    w_x_nxt        = x;
                    w_cnt_nxt      = CW'(POW - 1);
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = (POW > 1) ? S_POWR : S_GAIN;
                end
            end
            S_POWR: begin
                w_acc_nxt = w_mul[W-1:0];
                w_sat_nxt = r_sat | w_mul[W];
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_state_nxt = S_GAIN;
            end
            S_GAIN: begin
                w_acc_nxt   = w_mul[W-1:0];
                w_sat_nxt   = r_sat | w_mul[W];
                w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                w_i_out_nxt     = w_mul[W-1:0];
                w_out_sat_nxt   = r_sat | w_mul[W];
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign I_out     = r_i_out;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_gated_current_unit.sv
// Directed bench for gated_current_unit: instance 0 uses defaults (POW=4),
// instance 1 uses POW=1, instance 2 uses POW=2; all share clk and rst_n.
module tb_gated_current_unit;

    logic clk;
    logic rst_n;
    logic               iv [3];
    logic               ir [3];
    logic signed [15:0] vs [3];
    logic signed [15:0] xs [3];
    logic               ov [3];
    logic               ordy [3];
    logic signed [15:0] io [3];
    logic               os [3];

    int checks;
    int errors;

    gated_current_unit u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .V(vs[0]), .x(xs[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .I_out(io[0]), .out_sat(os[0])
    );

    gated_current_unit #(.POW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .V(vs[1]), .x(xs[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .I_out(io[1]), .out_sat(os[1])
    );

    gated_current_unit #(.POW(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .V(vs[2]), .x(xs[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .I_out(io[2]), .out_sat(os[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, scrambles inputs after acceptance, waits for the
    // result (bounded), reports latency/result, then consumes it.
    task automatic transact(input int k, input logic signed [15:0] xi,
                            input logic signed [15:0] vi, output int lat,
                            output logic signed [15:0] ri, output logic rs);
        lat = -1;
        ri  = '0;
        rs  = 1'b0;
        xs[k] = xi;
        vs[k] = vi;
        iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        xs[k] = 16'sh7abc;
        vs[k] = -16'sd77;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ov[k]) begin
                lat = n;
                break;
            end
        end
        ri = io[k];
        rs = os[k];
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || io[k] !== 16'sd0 || os[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d: got valid=%b I=%0d sat=%b want 0/0/0",
                         k, ov[k], io[k], os[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", ir[0]);
        end
    endtask

    task automatic test_case(input string name, input int k,
                             input logic signed [15:0] xi, input logic signed [15:0] vi,
                             input int exp_lat, input logic signed [15:0] exp_i,
                             input logic exp_s);
        int lat;
        logic signed [15:0] ri;
        logic rs;
        transact(k, xi, vi, lat, ri, rs);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (ri !== exp_i || rs !== exp_s) begin
            errors++;
            $display("FAIL %s_result: got I=%0d sat=%b want I=%0d sat=%b",
                     name, ri, rs, exp_i, exp_s);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        lat = -1;
        xs[0] = 16'sd128;
        vs[0] = 16'sd0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: in_ready got %b want 0", ir[0]);
        end
        // keep offering a different request that must be ignored
        xs[0] = 16'sd256;
        vs[0] = 16'sd1000;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ov[0]) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 5", lat);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (ov[0] !== 1'b1 || io[0] !== 16'sd6912 || os[0] !== 1'b0 || ir[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: got valid=%b I=%0d sat=%b rdy=%b want 1/6912/0/0",
                         c, ov[0], io[0], os[0], ir[0]);
            end
        end
        xs[0] = 16'sd256;
        vs[0] = -16'sd3072;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_consume: got valid=%b rdy=%b want 0/1", ov[0], ir[0]);
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        checks++;
        if (ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: in_ready got %b want 0", ir[0]);
        end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ov[0]) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 5 || io[0] !== 16'sd0 || os[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_result: got lat=%0d I=%0d sat=%b want 5/0/0",
                     lat, io[0], os[0]);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        xs[0] = 16'sd128;
        vs[0] = 16'sd0;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || io[0] !== 16'sd0 || os[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got valid=%b I=%0d sat=%b want 0/0/0",
                     ov[0], io[0], os[0]);
        end
        checks++;
        if (io[1] !== 16'sd0) begin
            errors++;
            $display("FAIL midreset_idle_inst: got I=%0d want 0", io[1]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b want 1", ir[0]);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ov[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_valid: got out_valid seen=%b want 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            vs[k]   = '0;
            xs[k]   = '0;
        end
        #2;
        test_reset();
        test_case("nominal",   0, 16'sd128, 16'sd0,      5, 16'sd6912,   1'b0);
        test_case("negative",  0, 16'sd256, -16'sd3328,  5, -16'sd9216,  1'b0);
        test_case("reversal",  0, 16'sd256, -16'sd3072,  5, 16'sd0,      1'b0);
        test_case("floor",     1, -16'sd1,  -16'sd3071,  2, -16'sd1,     1'b0);
        test_case("pow1",      1, 16'sd64,  16'sd0,      2, 16'sd27648,  1'b0);
        test_case("pow2",      2, 16'sd128, 16'sd0,      3, 16'sd27648,  1'b0);
        test_backpressure();
        test_case("sat_pos",   0, 16'sd256, 16'sd32512,  5, 16'sd32767,  1'b1);
        test_case("sat_neg",   0, 16'sd256, -16'sd32768, 5, -16'sd32768, 1'b1);
        test_reset_mid();
        test_case("recover",   0, 16'sd128, 16'sd0,      5, 16'sd6912,   1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gated_current_unit.md
GATED_CURRENT_UNIT -- requirements
Module: gated_current_unit

Interface
REQ-001 The block SHALL expose parameter W, default 16, meaning the signed data width of all operands and the result.
REQ-002 The block SHALL expose parameter FRAC, default 8, meaning the fractional bits of the fixed-point format (Q(W-FRAC).FRAC).
REQ-003 The block SHALL expose parameter POW, default 4, meaning the gating-variable exponent; legal range is 1..4.
REQ-004 The block SHALL expose parameter G_MAX, default 9216 (36.0), meaning the maximal conductance in the Q format.
REQ-005 The block SHALL expose parameter E_REV, default -3072 (-12.0), meaning the reversal potential in the Q format.
REQ-006 Port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-007 Port rst_n, input, 1, meaning the reset: asynchronous and active-low.
REQ-008 Port in_valid, input, 1, meaning V and x are presented.
REQ-009 Port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-010 Port V, input, W signed, meaning the membrane potential.
REQ-011 Port x, input, W signed, meaning the gating variable (n, m or h).
REQ-012 Port out_valid, output, 1, meaning I_out and out_sat hold a result.
REQ-013 Port out_ready, input, 1, meaning the consumer takes the result.
REQ-014 Port I_out, output, W signed, meaning I = G_MAX * x^POW * (V - E_REV).
REQ-015 Port out_sat, output, 1, meaning saturation occurred in any step of this result.

Function
REQ-016 A request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 in_ready SHALL be 1 only in state IDLE with out_valid == 0.
REQ-018 The FSM SHALL use states IDLE, POWR, GAIN, DRIVE, HOLD.
REQ-019 On acceptance the block SHALL register d = sat(V - E_REV) and acc = x, and SHALL enter POWR if POW > 1, else GAIN.
REQ-020 POWR SHALL last POW-1 cycles, each performing acc = mul(acc, x).
REQ-021 GAIN SHALL perform acc = mul(acc, G_MAX) for one cycle.
REQ-022 DRIVE SHALL perform I_out = mul(acc, d) and set out_valid = 1, entering HOLD.
REQ-023 mul(a,b) SHALL form the full 2W-bit signed product, arithmetically shift it right by FRAC (truncate toward minus infinity), and saturate it to [-2^(W-1), 2^(W-1)-1].
REQ-024 The subtraction V - E_REV SHALL be computed at W+1 bits and saturated to W bits.
REQ-025 out_sat SHALL be the OR of all saturation events in the computation and SHALL be valid while out_valid is 1.
REQ-026 Latency from the accepting edge to out_valid high SHALL be exactly POW+1 cycles (5 at default).
REQ-027 In HOLD, I_out, out_sat and out_valid SHALL remain stable until an edge with out_ready == 1, after which out_valid = 0 and the state is IDLE.
REQ-028 in_valid while not in_ready SHALL be ignored, with no effect on state or data.
REQ-029 V and x SHALL be sampled only at acceptance; later changes SHALL NOT affect the result in flight.
REQ-030 The next request SHALL be acceptable no earlier than the edge after the one where the result is consumed (no overlap).

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, out_valid = 0, I_out = 0, out_sat = 0, and clear acc and d, independent of clk.
REQ-032 Reset asserted mid-computation SHALL abandon the result; no out_valid SHALL follow the release of reset.
REQ-033 in_ready SHALL be 1 on the first cycle after rst_n is released.

Verification
REQ-034 Nominal: defaults, x = 128 (0.5), V = 0 -> after 5 cycles out_valid = 1, I_out = 6912 (27.0), out_sat = 0.
REQ-035 Negative drive: x = 256, V = -3328 -> I_out = -9216, out_sat = 0.
REQ-036 Reversal: x = 256, V = -3072 -> I_out = 0, out_sat = 0.
REQ-037 Saturation: x = 256, V = 32512 -> d saturates; I_out = 32767, out_sat = 1.
REQ-038 Backpressure: hold out_ready = 0 for 10 cycles with in_valid = 1 and new V -> I_out stable, in_ready = 0, second request not accepted until one edge after out_ready = 1.
REQ-039 Reset mid-operation: assert rst_n = 0 two cycles after acceptance -> outputs 0 asynchronously, no out_valid after release; rerun with POW = 1 and POW = 2 to confirm latencies of 2 and 3 cycles.
